// File: rtl/serial_rotate_unit.sv
// Multi-cycle SLL / SRA / ROR unit with start/busy/done handshake.
// Optional FAST_SHIFT_EN: moves 4 positions per clock while at least 4 remain.
module serial_rotate_unit #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out,
    output logic               err
);

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // One-position move of the working register for the latched operation.
    function automatic logic [WIDTH-1:0] shift1(input logic [1:0] m, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (m)
            MODE_SLL: r = {v[WIDTH-2:0], 1'b0};
            MODE_SRA: r = {v[WIDTH-1], v[WIDTH-1:1]};
            MODE_ROR: r = {v[0], v[WIDTH-1:1]};
            default:  r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        logic [SHAMT_W-1:0] step;
        state_d    = state_q;
        work_d     = work_q;
        count_d    = count_q;
        mode_d     = mode_q;
        data_out_d = data_out_q;
        err_d      = 1'b0;
        step       = SHAMT_W'(1);

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    mode_d  = mode;
                    work_d  = data_in;
                    count_d = shamt;
                    if (shamt == '0 || mode == MODE_ILL) begin
                        state_d    = DONE;
                        data_out_d = data_in;
                        err_d      = (mode == MODE_ILL);
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = shift1(mode_q, work_q);
`ifdef FAST_SHIFT_EN
                if (count_q >= SHAMT_W'(4)) begin
                    work_d = shift1(mode_q, shift1(mode_q, shift1(mode_q, shift1(mode_q, work_q))));
                    step   = SHAMT_W'(4);
                end
`endif
                count_d = count_q - step;
                if (count_d == '0) begin
                    state_d    = DONE;
                    data_out_d = work_d;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            work_q     <= '0;
            count_q    <= '0;
            mode_q     <= MODE_SLL;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;
    assign err      = err_q;

endmodule

// File: tb/tb_serial_rotate_unit.sv
// Directed self-checking bench for serial_rotate_unit.
module tb_serial_rotate_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] data_in;
    logic [3:0]  shamt;
    logic        busy;
    logic        done;
    logic [15:0] data_out;
    logic        err;

    int checks = 0;
    int errors = 0;

    serial_rotate_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .data_in  (data_in),
        .shamt    (shamt),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clocks from acceptance to done for a legal, nonzero shift.
    function automatic int lat(input int n);
`ifdef FAST_SHIFT_EN
        return (n >> 2) + (n & 3);
`else
        return n;
`endif
    endfunction

    // Issue one command, then wait for done; k counts negedges after E0.
    task automatic run_cmd(input string tag, input logic [1:0] m, input logic [15:0] d,
                           input logic [3:0] s, input logic [15:0] exp_d,
                           input logic exp_e, input int exp_lat);
        int k;
        int nbusy;
        @(negedge clk);
        start = 1'b1; mode = m; data_in = d; shamt = s;
        @(posedge clk);
        k = 0; nbusy = 0;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            k++;
        end
        check({tag, "_lat"}, 32'(k), 32'(exp_lat + 1));
        check({tag, "_busy"}, 32'(nbusy), 32'(exp_lat));
        check({tag, "_data"}, 32'(data_out), 32'(exp_d));
        check({tag, "_err"}, 32'(err), 32'(exp_e));
        @(negedge clk);
        check({tag, "_post"}, {29'd0, done, err, busy}, 32'd0);
        check({tag, "_hold"}, 32'(data_out), 32'(exp_d));
    endtask

    initial begin
        int k;
        int ndone;
        rst_n = 1'b0; start = 1'b0; mode = 2'b00; data_in = '0; shamt = '0;
        repeat (2) @(negedge clk);
        check("rst_outs", {13'd0, busy, done, err, data_out}, 32'd0);
        rst_n = 1'b1;

        run_cmd("ror", 2'b10, 16'h8001, 4'd4, 16'h1800, 1'b0, lat(4));

        // Reset mid-operation at E0+3.
        @(negedge clk);
        start = 1'b1; mode = 2'b10; data_in = 16'h1234; shamt = 4'd8;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid", {13'd0, busy, done, err, data_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rst_nodone", 32'(ndone), 32'd0);

        run_cmd("sra", 2'b01, 16'h8F00, 4'd3, 16'hF1E0, 1'b0, lat(3));
        run_cmd("sll15", 2'b00, 16'h0F0F, 4'd15, 16'h8000, 1'b0, lat(15));
        run_cmd("zero", 2'b10, 16'hABCD, 4'd0, 16'hABCD, 1'b0, 0);
        run_cmd("ill", 2'b11, 16'h5555, 4'd5, 16'h5555, 1'b1, 0);
        run_cmd("ror13", 2'b10, 16'h0001, 4'd13, 16'h0008, 1'b0, lat(13));

        // start held during busy with new operands, then accepted in DONE.
        @(negedge clk);
        start = 1'b1; mode = 2'b10; data_in = 16'h8001; shamt = 4'd4;
        @(posedge clk);
        @(negedge clk);
        mode = 2'b00; data_in = 16'h00FF; shamt = 4'd2;
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("hs_lat", 32'(k), 32'(lat(4) + 1));
        check("hs_first", 32'(data_out), 32'h1800);
        @(negedge clk);
        start = 1'b0;
        check("hs_b2b", {30'd0, busy, done}, 32'd2);
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("hs_lat2", 32'(k), 32'(lat(2) + 1));
        check("hs_second", 32'(data_out), 32'h03FC);
        check("hs_err", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
